// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared loader types: FSM state encoding, RAM address width, word-count decode
package inst_loader_pkg;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADR_L = 3'd1,
        ST_ADR_H = 3'd2,
        ST_CNT_L = 3'd3,
        ST_CNT_H = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSUM  = 3'd6
    } state_e;

    // A zero count field means a full 4096-word load.
    function automatic logic [CNT_W-1:0] word_count(input logic [7:0] lo, input logic [3:0] hi);
        logic [ADDR_W-1:0] raw;
        raw = {hi, lo};
        return (raw == '0) ? CNT_W'(1 << ADDR_W) : {1'b0, raw};
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte receive input and instruction RAM write / status bundle
interface inst_loader_if;
    import inst_loader_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] ram_wadr;
    logic [31:0]       ram_wdata;
    logic              ram_wen;
    logic              load_busy;
    logic              load_done;
    logic              load_err;

    modport master (
        input  rx_data, rx_valid,
        output ram_wadr, ram_wdata, ram_wen, load_busy, load_done, load_err
    );

    modport slave (
        output rx_data, rx_valid,
        input  ram_wadr, ram_wdata, ram_wen, load_busy, load_done, load_err
    );

endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - framed serial-byte loader writing 32-bit words into instruction RAM
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    inst_loader_if.master  bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reaches TIMEOUT_CYCLES-1 on the same edge that registers the abort.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wadr_q, wadr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              expire;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        wen_d      = 1'b0;
        wadr_d     = wadr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        expire = (state_q != ST_IDLE) && !bus.rx_valid && (tmo_q == TMO_LAST);

        if (state_q == ST_IDLE || bus.rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == HDR_BYTE) begin
                        state_d    = ST_ADR_L;
                        csum_d     = '0;
                        byte_idx_d = '0;
                    end
                end
                ST_ADR_L: begin
                    adr_d[7:0] = bus.rx_data;
                    state_d    = ST_ADR_H;
                end
                ST_ADR_H: begin
                    adr_d[ADDR_W-1:8] = bus.rx_data[3:0];
                    state_d           = ST_CNT_L;
                end
                ST_CNT_L: begin
                    cnt_d   = CNT_W'(bus.rx_data);
                    state_d = ST_CNT_H;
                end
                ST_CNT_H: begin
                    cnt_d   = word_count(cnt_q[7:0], bus.rx_data[3:0]);
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    // Shift in from the top so the first byte ends up in [7:0].
                    word_d     = {bus.rx_data, word_q[31:8]};
                    csum_d     = csum_q + bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wen_d   = 1'b1;
                        wadr_d  = adr_q;
                        wdata_d = {bus.rx_data, word_q[31:8]};
                        adr_d   = adr_q + 12'd1;
                        cnt_d   = cnt_q - 13'd1;
                        if (cnt_q == 13'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    done_d  = (bus.rx_data == csum_q);
                    err_d   = (bus.rx_data != csum_q);
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            wen_q      <= 1'b0;
            wadr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            wen_q      <= wen_d;
            wadr_q     <= wadr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.ram_wen   = wen_q;
    assign bus.ram_wadr  = wadr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.load_busy = busy_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;

endmodule
